// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode values, bubble encoding, instruction field
// positions and the fetch FSM state type.
package rv32_pkg;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] STORE   = 7'b0100011;
  localparam logic [6:0] LOAD    = 7'b0000011;
  localparam logic [6:0] BRANCH  = 7'b1100011;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] AUIPC   = 7'b0010111;
  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] FENCES  = 7'b0001111;
  localparam logic [6:0] SYSCALL = 7'b1110011;

  // addi x0,x0,0 : decodes as I_TYPE with rs1=rs2=0, so it never interlocks
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;

  typedef enum logic {
    FS_BOOT = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: valid/pc/instr with flush-to-bubble, load and hold.
// Priority is reset > flush > load > hold.
module if_id_reg
  import rv32_pkg::*;
#(
  parameter int          XLEN   = 32,
  parameter logic [31:0] BUBBLE = NOP_INSTR
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = BUBBLE;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= BUBBLE;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, BOOT/RUN FSM and IF/ID register with
// redirect > stall > advance priority. Decoded fields feed the interlock.
module fetch_stage
  import rv32_pkg::fetch_state_e;
  import rv32_pkg::FS_BOOT;
  import rv32_pkg::FS_RUN;
#(
  parameter int          XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic [6:0]      if_id_opcode,
  output logic [4:0]      if_id_read_reg1,
  output logic [4:0]      if_id_read_reg2,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush, advance;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush    = 1'b0;
    advance  = 1'b0;
    imem_req = 1'b0;
    case (state_q)
      FS_BOOT: begin
        state_d = FS_RUN;
      end
      FS_RUN: begin
        imem_req = 1'b1;
        // Redirect outranks stall: the wrong-path word must not survive a stall.
        if (redirect) begin
          pc_d  = redirect_pc & ~XLEN'(3);
          flush = 1'b1;
        end else if (!stall) begin
          pc_d    = pc_q + XLEN'(4);
          advance = 1'b1;
        end
      end
      default: state_d = FS_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .XLEN   (XLEN),
    .BUBBLE (NOP_INSTR)
  ) u_if_id (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .load     (advance),
    .pc_in    (pc_q),
    .instr_in (imem_rdata),
    .valid    (if_id_valid),
    .pc       (if_id_pc),
    .instr    (if_id_instr)
  );

  assign imem_addr       = pc_q;
  assign if_id_opcode    = if_id_instr[rv32_pkg::OPCODE_MSB:rv32_pkg::OPCODE_LSB];
  assign if_id_read_reg1 = if_id_instr[rv32_pkg::RS1_MSB:rv32_pkg::RS1_LSB];
  assign if_id_read_reg2 = if_id_instr[rv32_pkg::RS2_MSB:rv32_pkg::RS2_LSB];
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle expectations go into a queue,
// a monitor compares them after each rising edge; key points are also hand-checked.
module tb_fetch_stage;
  import rv32_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_opcode;
  logic [4:0]  if_id_read_reg1;
  logic [4:0]  if_id_read_reg2;
  fetch_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_opcode    (if_id_opcode),
    .if_id_read_reg1 (if_id_read_reg1),
    .if_id_read_reg2 (if_id_read_reg2),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // instruction memory: fixed words at interesting addresses, pattern elsewhere
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_000C: return 32'h0031_2223;
      32'h0000_0100: return 32'h0000_0463;
      32'hFFFF_FFFC: return 32'hFE00_0EE3;
      default:       return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  assign imem_rdata = imem_f(imem_addr);

  // expected state after one clock edge
  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        run;
    logic        valid;
    logic [31:0] ifpc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_pc    = 32'h0;
  logic        m_run   = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_ifpc  = 32'h0;
  logic [31:0] m_instr = 32'h0000_0013;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  // driver: apply one cycle of inputs and push the reference result
  task automatic step(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
    exp_t e;
    logic [31:0] rdata;
    reset       = rst;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    rdata = imem_f(m_pc);
    if (rst) begin
      m_pc = 32'h0; m_run = 1'b0; m_valid = 1'b0; m_ifpc = 32'h0; m_instr = 32'h0000_0013;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (rdr) begin
      m_pc = {rpc[31:2], 2'b00}; m_valid = 1'b0; m_ifpc = 32'h0; m_instr = 32'h0000_0013;
    end else if (!stl) begin
      m_ifpc = m_pc; m_instr = rdata; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.req = m_run; e.run = m_run; e.valid = m_valid;
    e.ifpc = m_ifpc; e.instr = m_instr;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // monitor / scoreboard
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("sb_pc",     imem_addr, e.pc);
      cmp("sb_req",    {31'b0, imem_req}, {31'b0, e.req});
      cmp("sb_state",  {31'b0, dbg_state == FS_RUN}, {31'b0, e.run});
      cmp("sb_valid",  {31'b0, if_id_valid}, {31'b0, e.valid});
      cmp("sb_if_pc",  if_id_pc, e.ifpc);
      cmp("sb_instr",  if_id_instr, e.instr);
      cmp("sb_opcode", {25'b0, if_id_opcode}, {25'b0, e.instr[6:0]});
      cmp("sb_rs1",    {27'b0, if_id_read_reg1}, {27'b0, e.instr[19:15]});
      cmp("sb_rs2",    {27'b0, if_id_read_reg2}, {27'b0, e.instr[24:20]});
    end
  end

  initial begin
    // 1: reset two clocks, release
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    cmp("rst_req",   {31'b0, imem_req}, 32'd0);
    cmp("rst_state", {31'b0, dbg_state == FS_BOOT}, 32'd1);
    cmp("rst_instr", if_id_instr, 32'h0000_0013);
    step(0, 0, 1, 32'h0000_0200);  // BOOT ignores redirect
    cmp("clk1_valid", {31'b0, if_id_valid}, 32'd0);
    cmp("clk1_pc",    imem_addr, 32'h0);
    step(0, 0, 0, 0);
    cmp("clk2_pc",     imem_addr, 32'h4);
    cmp("clk2_instr",  if_id_instr, 32'h00A0_0093);
    cmp("clk2_opcode", {25'b0, if_id_opcode}, 32'h13);
    cmp("clk2_valid",  {31'b0, if_id_valid}, 32'd1);
    // 2/3: straight line with a 3-cycle stall at pc=8
    step(0, 0, 0, 0);
    cmp("run_ifpc4", if_id_pc, 32'h4);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    cmp("stall_pc",   imem_addr, 32'h8);
    cmp("stall_ifpc", if_id_pc, 32'h4);
    step(0, 0, 0, 0);
    cmp("rel_pc",   imem_addr, 32'hC);
    cmp("rel_ifpc", if_id_pc, 32'h8);
    step(0, 0, 0, 0);
    cmp("run_ifpcC",  if_id_pc, 32'hC);
    cmp("run_instrC", if_id_instr, 32'h0031_2223);
    // 4: redirect with stall in the same cycle
    step(0, 1, 1, 32'h0000_0102);
    cmp("rdr_pc",     imem_addr, 32'h100);
    cmp("rdr_valid",  {31'b0, if_id_valid}, 32'd0);
    cmp("rdr_opcode", {25'b0, if_id_opcode}, 32'h13);
    cmp("rdr_rs1",    {27'b0, if_id_read_reg1}, 32'd0);
    cmp("rdr_rs2",    {27'b0, if_id_read_reg2}, 32'd0);
    step(0, 0, 0, 0);
    cmp("tgt_ifpc",  if_id_pc, 32'h100);
    cmp("tgt_instr", if_id_instr, 32'h0000_0463);
    // 5: PC wrap
    step(0, 0, 1, 32'hFFFF_FFFE);
    cmp("wrap_rdr_pc", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    cmp("wrap_pc",   imem_addr, 32'h0);
    cmp("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
    // 6: reset during stall with a valid entry
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0040);
    cmp("mid_rst_pc",    imem_addr, 32'h0);
    cmp("mid_rst_valid", {31'b0, if_id_valid}, 32'd0);
    cmp("mid_rst_instr", if_id_instr, 32'h0000_0013);
    cmp("mid_rst_state", {31'b0, dbg_state == FS_BOOT}, 32'd1);
    // mixed traffic after restart, checked by the scoreboard only
    step(0, 0, 0, 0);
    for (int i = 0; i < 24; i++)
      step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           32'h0000_0400 + 32'($urandom_range(0, 63)));
    // drain
    repeat (2) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
